ss_scan_decoder: RTL and testbench
==================================

Name: ss_scan_decoder

Overview:
- Reader end of the seven-segment display interface: observes the multiplexed anode/segment lines driven by the team's hex seven-segment encoder and scan logic, and recovers the displayed hex value of each digit.
- Used as an on-chip monitor/loopback checker and as a bench-side scoreboard front end.
- Synchronises the inputs, waits for each digit strobe to settle, decodes the segment pattern to a nibble, and publishes a complete frame once every digit has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (anode lines), 1..8
- STABLE_CYCLES, 16, consecutive unchanged synchronised cycles required before capture, 1..255
- SEG_ACTIVE_LOW, 1, 1 = segment lit when seg_i bit is 0; 0 = lit when 1
- AN_ACTIVE_LOW, 1, 1 = digit selected when an_i bit is 0

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- an_i  in  NUM_DIGITS  anode select lines, asynchronous to clk
- seg_i  in  7  segment lines; bit0=a, bit1=b ... bit6=g; asynchronous to clk
- digits_o  out  4*NUM_DIGITS  published frame; digit d in bits [4d+3:4d]
- digit_err_o  out  NUM_DIGITS  per-digit flag in the published frame: pattern was not a legal hex glyph
- frame_valid_o  out  1  one-cycle pulse when digits_o/digit_err_o update
- multi_an_err_o  out  1  one-cycle pulse when a stable window shows more than one anode active

Behaviour:
- Reset (async, rst_n=0) clears all outputs, synchroniser flops, the counter, the capture mask and the shadow registers to 0; state = IDLE.
- Input path: an_i and seg_i each pass through a 2-flop synchroniser. Polarity is then normalised, so lit = 1 and selected = 1.
- Stability counter cnt (8 bit):
  - cleared when the synced {an, seg} differs from its previous-cycle value;
  - otherwise increments, saturating at STABLE_CYCLES.
- State machine:
  - IDLE: no anode or more than one anode selected. Go to SETTLE when exactly one anode is selected.
  - SETTLE: exactly one anode selected, cnt < STABLE_CYCLES. Go to CAPTURE when cnt reaches STABLE_CYCLES. Go to IDLE if the anode set becomes zero or multi-hot.
  - CAPTURE: single-cycle action state. Writes the decoded nibble and error bit into the shadow slot of the active digit, then sets that digit's mask bit. Goes to HOLD.
  - HOLD: waits for any input change. On a change it goes to SETTLE (one-hot) or IDLE (otherwise). A pattern is never captured twice within one stable window.
- Multi-hot anodes stable for STABLE_CYCLES: pulse multi_an_err_o once per window. Nothing is captured.
- Decode table (active-high a..g to nibble): 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
- Any other pattern, including blank 00, stores nibble 0 with the error bit set.
- Frame publish:
  - Publish when the mask becomes all ones, including the same cycle as the final CAPTURE write.
  - On the next edge, copy the shadow into digits_o/digit_err_o, which then includes the just-captured digit.
  - Pulse frame_valid_o for 1 cycle and clear the mask.
  - A re-capture of an already-masked digit before frame completion overwrites its shadow slot (latest value wins).
- Latency: an input change settled at edge k gives a shadow write at edge k+2+STABLE_CYCLES+1. frame_valid_o follows the final capture by 1 cycle.
- Outputs hold between frames. digits_o never changes without frame_valid_o.
- Reset asserted mid-window or mid-frame discards partial data. No frame is published until every digit is re-captured.

Decomposition:
- Package ss_scan_pkg: 7-bit segment constants for the 16 glyphs, the state enum {IDLE, SETTLE, CAPTURE, HOLD} and a function seg_to_hex returning {err, nibble}.
- One natural sub-module: ss_sync2, a parameterised-width 2-flop synchroniser instanced for an_i and seg_i.

Test Plan:
- Reset released, inputs idle (an_i=4'hF, seg_i=7'h7F, active-low) → all outputs 0, no pulses for 1000 cycles.
- Scan digits 0..3 showing 1,2,3,4; 40 cycles per digit; active-low seg ~06, ~5B, ~4F, ~66 → exactly one frame_valid_o, digits_o=16'h4321, digit_err_o=0.
- Digit 2 driven with seg pattern 7'h00 (blank) in an otherwise legal frame → digit_err_o=4'b0100 and digit 2 nibble = 0.
- Dwell 10 cycles per digit (< STABLE_CYCLES=16) → no captures and no frame_valid_o.
- an_i=4'b1100 (two anodes low) held 30 cycles → one multi_an_err_o pulse; the next legal scan still yields a correct frame.
- rst_n pulsed low after 3 of 4 digits captured, then a full scan of A,b,C,d → single frame digits_o=16'hDCBA. The glitch-on-change case applies seg toggling every 5 cycles then stable → capture only the stable value.

Source files
------------

// File: rtl/ss_scan_pkg.sv
// Shared definitions for the seven-segment scan decoder: glyph constants,
// the capture state encoding and the segment-to-hex decode function.
package ss_scan_pkg;

  // Active-high segment patterns, bit0 = a ... bit6 = g
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_e;

  // Returns {err, nibble}; anything that is not one of the 16 glyphs
  // (blank included) decodes to nibble 0 with err set.
  function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      SEG_0:   res = 5'h00;
      SEG_1:   res = 5'h01;
      SEG_2:   res = 5'h02;
      SEG_3:   res = 5'h03;
      SEG_4:   res = 5'h04;
      SEG_5:   res = 5'h05;
      SEG_6:   res = 5'h06;
      SEG_7:   res = 5'h07;
      SEG_8:   res = 5'h08;
      SEG_9:   res = 5'h09;
      SEG_A:   res = 5'h0A;
      SEG_B:   res = 5'h0B;
      SEG_C:   res = 5'h0C;
      SEG_D:   res = 5'h0D;
      SEG_E:   res = 5'h0E;
      SEG_F:   res = 5'h0F;
      default: res = 5'h10;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ss_sync2.sv
// Two-flop synchroniser for a bus of asynchronous level inputs.
module ss_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give metastability a full cycle to resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ss_scan_decoder.sv
// Recovers the hex digits shown on a multiplexed seven-segment display by
// watching its anode and segment lines, and publishes whole frames.
module ss_scan_decoder
  import ss_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an_i,
  input  logic [6:0]              seg_i,
  output logic [4*NUM_DIGITS-1:0] digits_o,
  output logic [NUM_DIGITS-1:0]   digit_err_o,
  output logic                    frame_valid_o,
  output logic                    multi_an_err_o
);

  localparam int unsigned SIGW   = NUM_DIGITS + 7;
  localparam logic [7:0]  STABLE = 8'(STABLE_CYCLES);

  logic [NUM_DIGITS-1:0]   anSync;
  logic [6:0]              segSync;
  logic [NUM_DIGITS-1:0]   curAn;
  logic [6:0]              curSeg;
  logic [SIGW-1:0]         curSig;
  logic [SIGW-1:0]         prevSig_q;
  logic [NUM_DIGITS-1:0]   prevAn;
  logic                    changed;
  logic [3:0]              anCount;
  logic                    curOneHot;
  logic [7:0]              cnt_q, cnt_d;
  logic                    windowDone;
  state_e                  state_q, state_d;
  logic                    captureEn;
  logic [4:0]              decoded;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d;
  logic                    maskFull;
  logic [4*NUM_DIGITS-1:0] shadowDigits_q, shadowDigits_d;
  logic [NUM_DIGITS-1:0]   shadowErr_q, shadowErr_d;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   digitErr_q;
  logic                    frameValid_q;
  logic                    multiAn_q;

  ss_sync2 #(.WIDTH(NUM_DIGITS)) uSyncAn (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (an_i),
    .q_o   (anSync)
  );

  ss_sync2 #(.WIDTH(7)) uSyncSeg (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (seg_i),
    .q_o   (segSync)
  );

  // Normalise polarity so that selected/lit always reads as 1
  assign curAn     = AN_ACTIVE_LOW  ? ~anSync  : anSync;
  assign curSeg    = SEG_ACTIVE_LOW ? ~segSync : segSync;
  assign curSig    = {curAn, curSeg};
  assign changed   = (curSig != prevSig_q);
  assign prevAn    = prevSig_q[SIGW-1:7];
  assign curOneHot = (anCount == 4'd1);

  // Count selected anodes to tell idle, single-digit and multi-hot apart
  always_comb begin
    anCount = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      anCount = anCount + {3'b000, curAn[d]};
    end
  end

  // Stability counter: restart on any change, otherwise count up and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q < STABLE) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // A window completes on the single cycle the counter steps onto STABLE
  assign windowDone = !changed && (cnt_q == STABLE - 8'd1);

  // Capture sequencing; CAPTURE also watches for a change so none is missed
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (curOneHot) state_d = SETTLE;
      end
      SETTLE: begin
        if (!curOneHot) begin
          state_d = IDLE;
        end else if (!changed && cnt_q == STABLE) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (changed) begin
          state_d = curOneHot ? SETTLE : IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (changed) state_d = curOneHot ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // prevSig_q still holds the settled pattern while in CAPTURE
  assign captureEn = (state_q == CAPTURE);
  assign decoded   = seg_to_hex(prevSig_q[6:0]);
  assign maskFull  = &mask_q;

  // Shadow slot of the active digit takes the latest decoded glyph
  always_comb begin
    shadowDigits_d = shadowDigits_q;
    shadowErr_d    = shadowErr_q;
    if (captureEn) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        if (prevAn[d]) begin
          shadowDigits_d[4*d +: 4] = decoded[3:0];
          shadowErr_d[d]           = decoded[4];
        end
      end
    end
  end

  // Mask clears when a frame goes out and collects newly captured digits
  always_comb begin
    mask_d = maskFull ? '0 : mask_q;
    if (captureEn) mask_d = mask_d | prevAn;
  end

  // All state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevSig_q      <= '0;
      cnt_q          <= '0;
      state_q        <= IDLE;
      mask_q         <= '0;
      shadowDigits_q <= '0;
      shadowErr_q    <= '0;
      digits_q       <= '0;
      digitErr_q     <= '0;
      frameValid_q   <= 1'b0;
      multiAn_q      <= 1'b0;
    end else begin
      prevSig_q      <= curSig;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      mask_q         <= mask_d;
      shadowDigits_q <= shadowDigits_d;
      shadowErr_q    <= shadowErr_d;
      frameValid_q   <= maskFull;
      multiAn_q      <= windowDone && (anCount > 4'd1);
      if (maskFull) begin
        digits_q   <= shadowDigits_q;
        digitErr_q <= shadowErr_q;
      end
    end
  end

  assign digits_o       = digits_q;
  assign digit_err_o    = digitErr_q;
  assign frame_valid_o  = frameValid_q;
  assign multi_an_err_o = multiAn_q;

endmodule

// File: tb/tb_ss_scan_decoder.sv
// Directed bench for ss_scan_decoder with the default 4-digit, active-low setup.
module tb_ss_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  an_i = 4'hF;
  logic [6:0]  seg_i = 7'h7F;
  logic [15:0] digits_o;
  logic [3:0]  digit_err_o;
  logic        frame_valid_o;
  logic        multi_an_err_o;

  int checks = 0;
  int errors = 0;

  int          frameCount = 0;
  int          multiCount = 0;
  int          badChange  = 0;
  logic [15:0] lastDigits = '0;
  logic [3:0]  lastErr    = '0;
  logic [15:0] prevDigits = '0;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  ss_scan_decoder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .an_i           (an_i),
    .seg_i          (seg_i),
    .digits_o       (digits_o),
    .digit_err_o    (digit_err_o),
    .frame_valid_o  (frame_valid_o),
    .multi_an_err_o (multi_an_err_o)
  );

  always #5 clk = ~clk;

  // Watch outputs mid-cycle: count pulses, remember frames, flag silent updates
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid_o) begin
        frameCount = frameCount + 1;
        lastDigits = digits_o;
        lastErr    = digit_err_o;
      end
      if (multi_an_err_o) multiCount = multiCount + 1;
      if (!frame_valid_o && digits_o !== prevDigits) badChange = badChange + 1;
    end
    prevDigits = digits_o;
  end

  // Drive active-high anode/segment values onto the active-low pins for n cycles
  task automatic applyStimulus(input logic [3:0] anSel, input logic [6:0] segLit, input int n);
    an_i  = ~anSel;
    seg_i = ~segLit;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic showDigit(input int d, input logic [3:0] v, input int n);
    logic [3:0] sel;
    sel = 4'b0001 << d;
    applyStimulus(sel, GLYPH[v], n);
  endtask

  task automatic idle(input int n);
    applyStimulus(4'h0, 7'h00, n);
  endtask

  task automatic scan(input logic [15:0] vals, input int n);
    for (int d = 0; d < 4; d++) showDigit(d, vals[4*d +: 4], n);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(5);
    checks++;
    if (digits_o !== 16'h0 || digit_err_o !== 4'h0 || frame_valid_o !== 1'b0 || multi_an_err_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got digits=%h err=%b fv=%b multi=%b, expected all 0",
               digits_o, digit_err_o, frame_valid_o, multi_an_err_o);
    end
    rst_n = 1'b1;
    idle(1000);
    checks++;
    if (frameCount !== 0 || multiCount !== 0) begin
      errors++;
      $display("[TB] FAIL idle_pulses: got frames=%0d multi=%0d, expected 0 0", frameCount, multiCount);
    end
    checks++;
    if (digits_o !== 16'h0 || digit_err_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL idle_outputs: got digits=%h err=%b, expected 0000 0000", digits_o, digit_err_o);
    end
  endtask

  task automatic test_basic_scan;
    int f0;
    f0 = frameCount;
    scan(16'h4321, 40);
    idle(30);
    checks++;
    if (frameCount - f0 !== 1) begin
      errors++;
      $display("[TB] FAIL basic_frames: got %0d, expected 1", frameCount - f0);
    end
    checks++;
    if (lastDigits !== 16'h4321 || lastErr !== 4'h0) begin
      errors++;
      $display("[TB] FAIL basic_frame: got digits=%h err=%b, expected 4321 0000", lastDigits, lastErr);
    end
    checks++;
    if (digits_o !== 16'h4321) begin
      errors++;
      $display("[TB] FAIL basic_hold: got %h, expected 4321", digits_o);
    end
  endtask

  task automatic test_blank_digit;
    int f0;
    f0 = frameCount;
    showDigit(0, 4'h7, 40);
    showDigit(1, 4'h8, 40);
    applyStimulus(4'b0100, 7'h00, 40);
    showDigit(3, 4'h9, 40);
    idle(30);
    checks++;
    if (frameCount - f0 !== 1 || lastDigits !== 16'h9087 || lastErr !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL blank_digit: got frames=%0d digits=%h err=%b, expected 1 9087 0100",
               frameCount - f0, lastDigits, lastErr);
    end
  endtask

  task automatic test_short_dwell;
    int f0;
    f0 = frameCount;
    scan(16'h5555, 10);
    scan(16'h6666, 10);
    idle(40);
    checks++;
    if (frameCount - f0 !== 0 || digits_o !== 16'h9087) begin
      errors++;
      $display("[TB] FAIL short_dwell: got frames=%0d digits=%h, expected 0 9087", frameCount - f0, digits_o);
    end
  endtask

  task automatic test_multi_anode;
    int f0;
    int m0;
    f0 = frameCount;
    m0 = multiCount;
    applyStimulus(4'b0011, GLYPH[3], 30);
    idle(20);
    checks++;
    if (multiCount - m0 !== 1) begin
      errors++;
      $display("[TB] FAIL multi_pulse: got %0d pulses, expected 1", multiCount - m0);
    end
    checks++;
    if (frameCount - f0 !== 0) begin
      errors++;
      $display("[TB] FAIL multi_no_frame: got %0d frames, expected 0", frameCount - f0);
    end
    scan(16'h8765, 40);
    idle(30);
    checks++;
    if (frameCount - f0 !== 1 || lastDigits !== 16'h8765 || lastErr !== 4'h0) begin
      errors++;
      $display("[TB] FAIL multi_recover: got frames=%0d digits=%h err=%b, expected 1 8765 0000",
               frameCount - f0, lastDigits, lastErr);
    end
  endtask

  task automatic test_reset_mid_frame;
    int f0;
    showDigit(1, 4'h1, 40);
    showDigit(2, 4'h2, 40);
    showDigit(3, 4'h3, 40);
    idle(2);
    rst_n = 1'b0;
    idle(3);
    checks++;
    if (digits_o !== 16'h0 || digit_err_o !== 4'h0) begin
      errors++;
      $display("[TB] FAIL midreset_clear: got digits=%h err=%b, expected 0000 0000", digits_o, digit_err_o);
    end
    rst_n = 1'b1;
    idle(10);
    f0 = frameCount;
    scan(16'hDCBA, 40);
    idle(30);
    checks++;
    if (frameCount - f0 !== 1 || lastDigits !== 16'hDCBA || lastErr !== 4'h0) begin
      errors++;
      $display("[TB] FAIL midreset_frame: got frames=%0d digits=%h err=%b, expected 1 DCBA 0000",
               frameCount - f0, lastDigits, lastErr);
    end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = frameCount;
    showDigit(1, 4'h2, 40);
    showDigit(2, 4'h3, 40);
    showDigit(3, 4'h4, 40);
    for (int i = 0; i < 8; i++) showDigit(0, (i % 2 == 0) ? 4'h8 : 4'h0, 5);
    showDigit(0, 4'hE, 40);
    idle(30);
    checks++;
    if (frameCount - f0 !== 1 || lastDigits !== 16'h432E) begin
      errors++;
      $display("[TB] FAIL glitch: got frames=%0d digits=%h, expected 1 432E", frameCount - f0, lastDigits);
    end
  endtask

  task automatic test_latest_wins;
    int f0;
    f0 = frameCount;
    showDigit(0, 4'h1, 40);
    showDigit(0, 4'h9, 40);
    showDigit(1, 4'h5, 40);
    showDigit(2, 4'h6, 40);
    showDigit(3, 4'h7, 40);
    idle(30);
    checks++;
    if (frameCount - f0 !== 1 || lastDigits !== 16'h7659) begin
      errors++;
      $display("[TB] FAIL latest_wins: got frames=%0d digits=%h, expected 1 7659", frameCount - f0, lastDigits);
    end
  endtask

  task automatic test_back_to_back;
    int f0;
    f0 = frameCount;
    scan(16'h0F1E, 40);
    scan(16'hFEDC, 40);
    idle(30);
    checks++;
    if (frameCount - f0 !== 2 || lastDigits !== 16'hFEDC || digits_o !== 16'hFEDC) begin
      errors++;
      $display("[TB] FAIL back_to_back: got frames=%0d last=%h out=%h, expected 2 FEDC FEDC",
               frameCount - f0, lastDigits, digits_o);
    end
    checks++;
    if (badChange !== 0) begin
      errors++;
      $display("[TB] FAIL silent_update: got %0d output changes without frame_valid, expected 0", badChange);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_basic_scan;
    test_blank_digit;
    test_short_dwell;
    test_multi_anode;
    test_reset_mid_frame;
    test_glitch;
    test_latest_wins;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
